// File: rtl/mul_div_sequencer_pkg.sv
// Shared types for the multiply/divide sequencer: operation codes, FSM states,
// and the iteration-counter width helper.
package mulDivPkg;

  typedef enum logic [1:0] {
    UMUL = 2'd0,
    SMUL = 2'd1,
    UDIV = 2'd2,
    SDIV = 2'd3
  } md_op_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PREP  = 3'd1,
    ITER  = 3'd2,
    FIXUP = 3'd3,
    DONE  = 3'd4
  } md_state_t;

  // Counter only has to reach WIDTH-1, so clog2(WIDTH) bits are enough.
  function automatic int md_cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/mul_div_iter_unit.sv
// Iterative datapath shared by multiply and divide.
// acc holds {hi, lo}: for multiply it is {partial product, remaining multiplier};
// for divide it is {partial remainder, dividend bits shifting into quotient}.
module mul_div_iter_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a_mag,
  input  logic [WIDTH-1:0] b_mag,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0]   opnd;      // multiplicand or divisor
  logic [WIDTH:0]     mul_sum;   // upper half plus carry out
  logic [WIDTH:0]     rem_t;     // remainder shifted left with next dividend bit
  logic [WIDTH-1:0]   rem_sub;   // only used when rem_t >= opnd, so it fits in WIDTH

  // One shift-add or restoring-subtract step.
  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    rem_t   = acc[2*WIDTH-1:WIDTH-1];
    rem_sub = rem_t[WIDTH-1:0] - opnd;
    if (is_div) begin
      if (rem_t >= {1'b0, opnd}) acc_nxt = {rem_sub, acc[WIDTH-2:0], 1'b1};
      else                       acc_nxt = {rem_t[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_nxt = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  // Load operands on init, advance one bit per step.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc  <= '0;
      opnd <= '0;
    end else if (init) begin
      acc  <= {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
      opnd <= is_div ? b_mag : a_mag;
    end else if (step) begin
      acc  <= acc_nxt;
    end
  end

  assign hi = acc[2*WIDTH-1:WIDTH];
  assign lo = acc[WIDTH-1:0];

endmodule

// File: rtl/mul_div_sequencer.sv
// Multi-cycle controller for UMUL/SMUL/UDIV/SDIV: sign preparation, WIDTH
// iterations in mul_div_iter_unit, sign fix-up, and divide-by-zero reporting.
module mul_div_sequencer
  import mulDivPkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  md_op_t           op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic             div_by_zero
);

  localparam int CNT_W = md_cnt_w(WIDTH);

  md_state_t        state, state_nxt;
  md_op_t           op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [CNT_W-1:0] cnt;
  logic             res_neg, rem_neg;

  logic             accept, is_div, is_signed, a_neg, b_neg, div0;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             init, step;
  logic [WIDTH-1:0] u_hi, u_lo;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] fix_hi, fix_lo;

  assign accept    = (state == IDLE) && start && !abort;
  assign is_div    = (op_q == UDIV) || (op_q == SDIV);
  assign is_signed = (op_q == SMUL) || (op_q == SDIV);
  assign a_neg     = is_signed && a_q[WIDTH-1];
  assign b_neg     = is_signed && b_q[WIDTH-1];
  assign a_mag     = a_neg ? (~a_q + 1'b1) : a_q;
  assign b_mag     = b_neg ? (~b_q + 1'b1) : b_q;
  assign div0      = is_div && (b_q == '0);

  mul_div_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .reset  (reset),
    .init   (init),
    .step   (step),
    .is_div (is_div),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .hi     (u_hi),
    .lo     (u_lo)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; abort always wins over progress or a new start.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = PREP;
      PREP:    if (abort) state_nxt = IDLE;
               else if (div0) state_nxt = DONE;
               else state_nxt = ITER;
      ITER:    if (abort) state_nxt = IDLE;
               else if (cnt == '0) state_nxt = FIXUP;
      FIXUP:   state_nxt = abort ? IDLE : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore outputs and datapath controls.
  always_comb begin
    busy = (state == PREP) || (state == ITER) || (state == FIXUP);
    done = (state == DONE);
    init = (state == PREP);
    step = (state == ITER);
  end

  // Final sign correction of the unsigned iteration result.
  always_comb begin
    prod_fix = res_neg ? (~{u_hi, u_lo} + 1'b1) : {u_hi, u_lo};
    if (is_div) begin
      fix_lo = res_neg ? (~u_lo + 1'b1) : u_lo;
      fix_hi = rem_neg ? (~u_hi + 1'b1) : u_hi;
    end else begin
      fix_lo = prod_fix[WIDTH-1:0];
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
    end
  end

  // Operand capture, sign bookkeeping and iteration counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q    <= UMUL;
      a_q     <= '0;
      b_q     <= '0;
      res_neg <= 1'b0;
      rem_neg <= 1'b0;
      cnt     <= '0;
    end else begin
      if (accept) begin
        op_q <= op;
        a_q  <= operand_a;
        b_q  <= operand_b;
      end
      if (state == PREP) begin
        res_neg <= a_neg ^ b_neg;
        rem_neg <= a_neg;
        cnt     <= CNT_W'(WIDTH-1);
      end else if (state == ITER) begin
        cnt     <= cnt - 1'b1;
      end
    end
  end

  // Results change only on entry to DONE; the flag clears on the next acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_hi   <= '0;
      result_lo   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (accept) div_by_zero <= 1'b0;
      if (state == PREP && !abort && div0) begin
        result_hi   <= a_q;
        result_lo   <= '1;
        div_by_zero <= 1'b1;
      end else if (state == FIXUP && !abort) begin
        result_hi   <= fix_hi;
        result_lo   <= fix_lo;
      end
    end
  end

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Directed bench for mul_div_sequencer (WIDTH=32): hand-computed products,
// quotients, latencies, abort and reset behaviour.
module tb_mul_div_sequencer;
  import mulDivPkg::*;

  logic        clk = 1'b0;
  logic        reset, start, abort;
  md_op_t      op;
  logic [31:0] operand_a, operand_b;
  logic        busy, done, div_by_zero;
  logic [31:0] result_hi, result_lo;

  int checks   = 0;
  int failures = 0;

  mul_div_sequencer #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .abort       (abort),
    .busy        (busy),
    .done        (done),
    .result_hi   (result_hi),
    .result_lo   (result_lo),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation from IDLE and wait (bounded) for done.
  task automatic run_op(input md_op_t o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input logic ed,
                        input int ecyc, input string tag);
    int cyc;
    int bcnt;
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    tick();
    start = 1'b0;
    cyc  = 1;
    bcnt = 0;
    while (!done && cyc < 60) begin
      if (busy) bcnt++;
      tick();
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(ecyc));
    check({tag, "_busycycles"}, 64'(bcnt), 64'(ecyc - 1));
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    check({tag, "_hi"}, 64'(result_hi), 64'(eh));
    check({tag, "_lo"}, 64'(result_lo), 64'(el));
    check({tag, "_dbz"}, 64'(div_by_zero), 64'(ed));
    tick();
  endtask

  initial begin
    int donecnt;
    reset = 1'b1; start = 1'b0; abort = 1'b0; op = UMUL;
    operand_a = '0; operand_b = '0;
    tick();
    tick();
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hi",   64'(result_hi), 64'd0);
    check("reset_lo",   64'(result_lo), 64'd0);
    check("reset_dbz",  64'(div_by_zero), 64'd0);
    reset = 1'b0;
    tick();

    // Multiply
    run_op(UMUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 35, "umul_max");
    run_op(SMUL, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 35, "smul_neg3x7");
    run_op(SMUL, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 35, "smul_minxmin");

    // Divide
    run_op(UDIV, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 35, "udiv_100_7");
    run_op(SDIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 35, "sdiv_neg7_2");
    run_op(SDIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 35, "sdiv_min_neg1");

    // Divide by zero, then the flag clears on the next operation
    run_op(UDIV, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1, 2, "udiv_by0");
    run_op(UMUL, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 35, "umul_2x3");

    // Abort at cycle 12; start at cycle 5 (busy) and at cycle 12 (with abort) are dropped
    start = 1'b1; op = UMUL; operand_a = 32'd5; operand_b = 32'd5;
    tick();
    start = 1'b0;
    donecnt = 0;
    for (int c = 1; c <= 45; c++) begin
      if (done) donecnt++;
      if (c == 6)  check("abort_busy_c6", 64'(busy), 64'd1);
      if (c == 13) begin
        check("abort_busy_c13", 64'(busy), 64'd0);
        check("abort_done_c13", 64'(done), 64'd0);
        check("abort_hi_kept",  64'(result_hi), 64'd0);
        check("abort_lo_kept",  64'(result_lo), 64'd6);
      end
      if (c == 14) check("abort_start_dropped", 64'(busy), 64'd0);
      start = (c == 5) || (c == 12);
      abort = (c == 12);
      operand_a = (c == 5) ? 32'd7 : 32'd9;
      operand_b = (c == 5) ? 32'd7 : 32'd9;
      tick();
    end
    start = 1'b0; abort = 1'b0;
    check("abort_no_done", 64'(donecnt), 64'd0);
    check("abort_lo_final", 64'(result_lo), 64'd6);

    // Synchronous reset in the middle of an SDIV
    start = 1'b1; op = SDIV; operand_a = 32'hFFFFFF9C; operand_b = 32'd7;
    tick();
    start = 1'b0;
    for (int c = 1; c < 20; c++) tick();
    check("rst_busy_c20", 64'(busy), 64'd1);
    reset = 1'b1;
    tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi",   64'(result_hi), 64'd0);
    check("rst_lo",   64'(result_lo), 64'd0);
    check("rst_dbz",  64'(div_by_zero), 64'd0);
    reset = 1'b0;
    tick();
    run_op(UDIV, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0, 35, "udiv_9_3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_div_sequencer.md
Name: mul_div_sequencer

Overview:
Multi-cycle controller and iterative engine for the SMUL_R, UMUL_R, SDIV_R and UDIV_R instruction classes. It sits beside the execute stage. The main controller decodes one of these one-hot instruction classes, pulses start with the operation code, and stalls on busy until done. The block sequences sign preparation, WIDTH shift-add or restoring-subtract iterations, and sign fix-up. It reports divide-by-zero to the exception logic.

Parameters:
WIDTH, 32, operand width; results are 2*WIDTH split into hi/lo; must be >= 4 and even.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; accepted only in IDLE when abort=0
op  input  2  mulDivPkg::md_op_t: UMUL=0, SMUL=1, UDIV=2, SDIV=3; sampled with start
operand_a  input  WIDTH  multiplicand / dividend; sampled with start
operand_b  input  WIDTH  multiplier / divisor; sampled with start
abort  input  1  flush (interrupt/exception); cancels any operation in flight
busy  output  1  high from the cycle after acceptance until the cycle DONE is reached
done  output  1  one-cycle pulse; results valid in the same cycle
result_hi  output  WIDTH  mul: product[2W-1:W]; div: remainder
result_lo  output  WIDTH  mul: product[W-1:0]; div: quotient
div_by_zero  output  1  valid with done; high only for UDIV/SDIV with operand_b==0

Behaviour:
- Reset: state=IDLE; busy=0, done=0, div_by_zero=0, result_hi=0, result_lo=0; iteration counter=0.
- States (mulDivPkg::md_state_t): IDLE, PREP, ITER, FIXUP, DONE.
- IDLE: on start&&!abort, latch op and operands -> PREP. start in any other state is ignored, with no queuing.
- PREP (1 cycle):
  - Signed ops take magnitudes and record the result sign and the remainder sign (the dividend's sign).
  - Division with operand_b==0 -> DONE directly, with result_lo=all ones, result_hi=operand_a (raw), div_by_zero=1.
  - Otherwise clear the accumulator, set counter=WIDTH-1 -> ITER.
- ITER (exactly WIDTH cycles, counter decrements, -> FIXUP when counter==0):
  - Mul: radix-2 shift-add on the unsigned magnitudes, 2W-bit accumulator.
  - Div: restoring; shift the remainder left by one with the next dividend bit; if remainder >= divisor, subtract and shift in 1, else 0.
- FIXUP (1 cycle):
  - SMUL: negate the 2W-bit product if the operand signs differ.
  - SDIV: negate the quotient if the signs differ; negate the remainder if the dividend is negative.
  - Quotient truncates toward zero.
  - -2^(W-1) / -1 yields quotient 0x80000000 and remainder 0 with no flag (natural wrap).
- DONE (1 cycle): done=1, busy=0 -> IDLE. A new start is accepted in the following IDLE cycle.
- Latency: start accepted at cycle 0 -> done at cycle WIDTH+3 (35 for W=32). Divide-by-zero -> done at cycle 2.
- result_hi/lo and div_by_zero update only on entry to DONE and hold until the next DONE or reset. div_by_zero is cleared on the next acceptance.
- busy=1 in PREP, ITER and FIXUP; 0 in IDLE and DONE.
- abort in any non-IDLE state -> IDLE next cycle, no done, results unchanged.
- abort and start in the same cycle: abort wins, start is dropped.
- reset mid-operation: immediate return to the reset values above.

Decomposition:
- Package mulDivPkg: md_op_t, md_state_t, a helper constant for the counter width ($clog2(WIDTH)).
- One sub-module, mul_div_iter_unit: accumulator/remainder/quotient registers plus the single-step add/subtract. Controlled by init, step and is_div inputs.
- The FSM, sign handling and fix-up stay in mul_div_sequencer.

Test Plan:
1. UMUL 0xFFFFFFFF*0xFFFFFFFF -> done at cycle 35, hi=0xFFFFFFFE, lo=0x00000001, busy high cycles 1-34.
2. SMUL 0xFFFFFFFD(-3)*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. SMUL 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
3. UDIV 100/7 -> lo=14, hi=2. SDIV 0xFFFFFFF9(-7)/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. SDIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
4. UDIV 5/0 -> done at cycle 2, div_by_zero=1, lo=0xFFFFFFFF, hi=5. The next UMUL 2*3 gives div_by_zero=0, lo=6.
5. start UMUL, abort at cycle 12 -> busy=0 from cycle 13, no done, results keep their prior values. A start in the same cycle as abort is dropped. A start pulsed at cycle 5 while busy is ignored.
6. reset asserted at cycle 20 of an SDIV -> all outputs 0 next cycle. A fresh UDIV 9/3 then completes with lo=3, hi=0 at cycle 35.
